// File: rtl/bram_ms_pkg.sv
// Shared types and legal parameter ranges for bram_master.
// Also provides default ADDR_WIDTH / DATA_WIDTH macros if the build does not set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package bram_ms_pkg;

    localparam int RD_LAT_MIN    = 1;
    localparam int RD_LAT_MAX    = 4;
    localparam int RSP_DEPTH_MIN = 2;
    localparam int RSP_DEPTH_MAX = 16;

    typedef struct packed {
        logic [`DATA_WIDTH-1:0] rdata;
        logic                   is_wr;
    } rsp_entry_t;

endpackage

// File: rtl/bram_ms_rsp_fifo.sv
// Response FIFO for bram_master: storage and pointers are flops, head entry read straight from them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bram_ms_rsp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic valid,
    output T     data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        empty;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign valid = !empty;
    assign data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bram_master.sv
// Request/response front end for a block RAM port with fixed read latency RD_LAT.
// Optional feature: define BRAM_MS_WR_ACK_EN to return an ordered ack entry for every write.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module bram_master
    import bram_ms_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [`ADDR_WIDTH-1:0] req_addr,
    input  logic [`DATA_WIDTH-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [`DATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_is_wr,
    output logic                   bram_en,
    output logic                   bram_wen,
    output logic [`ADDR_WIDTH-1:0] bram_addr,
    output logic [`DATA_WIDTH-1:0] bram_datai,
    input  logic [`DATA_WIDTH-1:0] bram_datao
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("bram_master: RD_LAT out of range");
    end
    if (RSP_DEPTH < RSP_DEPTH_MIN || RSP_DEPTH > RSP_DEPTH_MAX ||
        (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bram_master: RSP_DEPTH must be a power of two in range");
    end

    logic            accept;
    logic            acc_rsp;
    logic            pop;
    logic [CW-1:0]   credit;
    logic [RD_LAT:0] vld_pipe;
    rsp_entry_t      push_entry;
    rsp_entry_t      head;

    assign accept    = req_valid && req_ready;
    // Credit covers everything that will occupy a FIFO slot, so a push can never find it full.
    assign req_ready = (credit < CW'(RSP_DEPTH));
    assign pop       = rsp_valid && rsp_ready;

`ifdef BRAM_MS_WR_ACK_EN
    logic [RD_LAT:0] wr_pipe;

    assign acc_rsp = accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_pipe <= '0;
        else       wr_pipe <= {wr_pipe[RD_LAT-1:0], req_we};
    end

    // Write acks ride the same pipe as reads so they land in request order.
    assign push_entry = '{rdata: (wr_pipe[RD_LAT] ? '0 : bram_datao), is_wr: wr_pipe[RD_LAT]};
`else
    assign acc_rsp    = accept && !req_we;
    assign push_entry = '{rdata: bram_datao, is_wr: 1'b0};
`endif

    // Issue register; address and write data only move when they are meaningful.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_en    <= 1'b0;
            bram_wen   <= 1'b0;
            bram_addr  <= '0;
            bram_datai <= '0;
            vld_pipe   <= '0;
        end else begin
            bram_en  <= accept;
            bram_wen <= accept && req_we;
            if (accept)           bram_addr  <= req_addr;
            if (accept && req_we) bram_datai <= req_wdata;
            vld_pipe <= {vld_pipe[RD_LAT-1:0], acc_rsp};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit <= '0;
        end else begin
            case ({acc_rsp, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    bram_ms_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_entry_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_pipe[RD_LAT]),
        .push_data (push_entry),
        .pop       (pop),
        .valid     (rsp_valid),
        .data      (head)
    );

    assign rsp_rdata = head.rdata;
    assign rsp_is_wr = head.is_wr;

endmodule

// File: tb/tb_bram_master.sv
// Directed bench for bram_master: RD_LAT=1/RSP_DEPTH=4 instance plus an RD_LAT=3 instance.
// Each instance is backed by a behavioural block RAM with matching latency.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_bram_master;

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
`ifdef BRAM_MS_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_is_wr, bram_en, bram_wen;
    logic [DW-1:0] rsp_rdata, bram_datai, bram_datao;
    logic [AW-1:0] bram_addr;

    logic          q3_valid = 1'b0, q3_we = 1'b0, s3_ready = 1'b0;
    logic [AW-1:0] q3_addr = '0;
    logic [DW-1:0] q3_wdata = '0;
    logic          q3_ready, s3_valid, s3_is_wr, b3_en, b3_wen;
    logic [DW-1:0] s3_rdata, b3_datai, b3_datao;
    logic [AW-1:0] b3_addr;

    bram_master #(.RD_LAT(1), .RSP_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_is_wr(rsp_is_wr),
        .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
        .bram_datai(bram_datai), .bram_datao(bram_datao)
    );

    bram_master #(.RD_LAT(3), .RSP_DEPTH(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(q3_valid), .req_ready(q3_ready), .req_we(q3_we),
        .req_addr(q3_addr), .req_wdata(q3_wdata),
        .rsp_valid(s3_valid), .rsp_ready(s3_ready), .rsp_rdata(s3_rdata), .rsp_is_wr(s3_is_wr),
        .bram_en(b3_en), .bram_wen(b3_wen), .bram_addr(b3_addr),
        .bram_datai(b3_datai), .bram_datao(b3_datao)
    );

    // Behavioural RAMs: mem3 preloaded with 'h100 + 3*addr while reset is high.
    logic [DW-1:0] mem1 [1<<AW];
    logic [DW-1:0] mem3 [1<<AW];
    logic [DW-1:0] rd1;
    logic [DW-1:0] p3 [3];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1<<AW); i++) begin
                mem1[i] <= '0;
                mem3[i] <= DW'(32'h100 + 3 * i);
            end
        end else begin
            if (bram_en) begin
                if (bram_wen) mem1[bram_addr] <= bram_datai;
                rd1 <= mem1[bram_addr];
            end
            if (b3_en) begin
                if (b3_wen) mem3[b3_addr] <= b3_datai;
                p3[0] <= mem3[b3_addr];
            end
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end

    assign bram_datao = rd1;
    assign b3_datao   = p3[2];

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_is_wr, bram_en, bram_wen} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctl: got rdy/vld/iswr/en/wen=%b%b%b%b%b want 10000",
                     req_ready, rsp_valid, rsp_is_wr, bram_en, bram_wen);
        end
        n_cmp++;
        if (rsp_rdata !== '0 || bram_addr !== '0 || bram_datai !== '0) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%0h addr=%0h datai=%0h want 0/0/0",
                     rsp_rdata, bram_addr, bram_datai);
        end
        n_cmp++;
        if ({q3_ready, s3_valid, b3_en} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_lat3: got rdy/vld/en=%b%b%b want 100", q3_ready, s3_valid, b3_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(3); req_wdata = DW'(32'hA5);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_ready: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bram_en, bram_wen} !== 2'b11 || bram_addr !== AW'(3) || bram_datai !== DW'(32'hA5)) begin
            n_err++;
            $display("FAIL issue_wr: got en/wen=%b%b addr=%0h datai=%0h want 11/3/a5",
                     bram_en, bram_wen, bram_addr, bram_datai);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bram_en, bram_wen} !== 2'b10 || bram_addr !== AW'(3) || bram_datai !== DW'(32'hA5)) begin
            n_err++;
            $display("FAIL issue_rd: got en/wen=%b%b addr=%0h datai=%0h want 10/3/a5",
                     bram_en, bram_wen, bram_addr, bram_datai);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (bram_en !== 1'b0 || rsp_valid !== WR_ACK || (WR_ACK && rsp_is_wr !== 1'b1)) begin
            n_err++;
            $display("FAIL rd_pending: got en=%b vld=%b iswr=%b want 0/%b/%b",
                     bram_en, rsp_valid, rsp_is_wr, WR_ACK, WR_ACK);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== DW'(32'hA5) || rsp_is_wr !== 1'b0) begin
            n_err++;
            $display("FAIL rd_data: got vld=%b rdata=%0h iswr=%b want 1/a5/0",
                     rsp_valid, rsp_rdata, rsp_is_wr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_single: got vld=%b want 0", rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_credit();
        int acc;
        int got;
        logic took;
        rsp_ready = 1'b1;
        req_we = 1'b1; req_valid = 1'b1;
        for (int a = 10; a < 15; a++) begin
            req_addr = AW'(a); req_wdata = DW'(32'hD000 + a);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(10); acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = req_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                req_addr = AW'(10 + acc);
            end
        end
        n_cmp++;
        if (acc != 4) begin
            n_err++; $display("FAIL fill_accepts: got %0d want 4", acc);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== DW'(32'hD00A)) begin
            n_err++;
            $display("FAIL full_pop: got rdy=%b vld=%b rdata=%0h want 0/1/d00a",
                     req_ready, rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_rdata !== DW'(32'hD00B)) begin
            n_err++;
            $display("FAIL credit_free: got rdy=%b rdata=%0h want 1/d00b", req_ready, rsp_rdata);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_rdata !== DW'(32'hD00C)) begin
            n_err++;
            $display("FAIL acc_pop_hold: got rdy=%b rdata=%0h want 1/d00c", req_ready, rsp_rdata);
        end
        got = 3;
        for (int c = 0; c < 10 && got < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_rdata !== DW'(32'hD000 + 10 + got)) begin
                    n_err++;
                    $display("FAIL drain_order: got %0h want %0h", rsp_rdata, 32'hD000 + 10 + got);
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 5) begin
            n_err++; $display("FAIL drain_count: got %0d want 5", got);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int bad;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(10);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_ready_pre: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_addr = AW'(11);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || bram_en !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL mid_reset_flush: got %0d cycles with rsp_valid/bram_en want 0", bad);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_wr_ack();
        int n;
        logic          got_wr [4];
        logic [DW-1:0] got_d  [4];
        logic          exp_wr [3];
        logic [DW-1:0] exp_d  [3];
        int            exp_n;
        if (WR_ACK) begin
            exp_n = 3;
            exp_wr[0] = 1'b1; exp_d[0] = '0;
            exp_wr[1] = 1'b0; exp_d[1] = DW'(32'h55);
            exp_wr[2] = 1'b1; exp_d[2] = '0;
        end else begin
            exp_n = 1;
            exp_wr[0] = 1'b0; exp_d[0] = DW'(32'h55);
            exp_wr[1] = 1'b0; exp_d[1] = '0;
            exp_wr[2] = 1'b0; exp_d[2] = '0;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(20); req_wdata = DW'(32'h55);
        @(posedge clk); #1;
        req_we = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = AW'(21); req_wdata = DW'(32'h66);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid && n < 4) begin
                got_wr[n] = rsp_is_wr;
                got_d[n]  = rsp_rdata;
                n++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n != exp_n) begin
            n_err++; $display("FAIL ack_count: got %0d want %0d", n, exp_n);
        end
        for (int i = 0; i < exp_n && i < n; i++) begin
            n_cmp++;
            if (got_wr[i] !== exp_wr[i] || got_d[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL ack_entry%0d: got iswr=%b rdata=%0h want %b/%0h",
                         i, got_wr[i], got_d[i], exp_wr[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_rdlat3();
        int acc, got, run, maxrun;
        logic took;
        acc = 0; got = 0; run = 0; maxrun = 0;
        s3_ready = 1'b1;
        q3_valid = 1'b1; q3_we = 1'b0; q3_addr = AW'(40);
        for (int c = 0; c < 80 && got < 16; c++) begin
            @(negedge clk);
            run = b3_en ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (s3_valid) begin
                n_cmp++;
                if (s3_rdata !== DW'(32'h100 + 3 * (40 + got)) || s3_is_wr !== 1'b0) begin
                    n_err++;
                    $display("FAIL lat3_data%0d: got %0h/%b want %0h/0",
                             got, s3_rdata, s3_is_wr, 32'h100 + 3 * (40 + got));
                end
                got++;
            end
            took = q3_valid && q3_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                if (acc == 16) q3_valid = 1'b0;
                else           q3_addr  = AW'(40 + acc);
            end
        end
        n_cmp++;
        if (got != 16) begin
            n_err++; $display("FAIL lat3_count: got %0d want 16", got);
        end
        n_cmp++;
        if (maxrun != 4) begin
            n_err++; $display("FAIL lat3_burst: got run %0d want 4", maxrun);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_credit();
        test_reset_mid();
        test_wr_ack();
        test_rdlat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
